// File: rtl/rotate_left_if.sv
// Handshake bundle for rotate_left_seq: start/operands in, ready/done_tick/result out.
interface rotate_left_if #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
);
  logic              start;
  logic [DATA_W-1:0] a;
  logic [AMT_W-1:0]  amt;
  logic              ready;
  logic              done_tick;
  logic [DATA_W-1:0] y;

  modport master (
    output start, a, amt,
    input  ready, done_tick, y
  );

  modport slave (
    input  start, a, amt,
    output ready, done_tick, y
  );
endinterface

// File: rtl/rotate_left_seq.sv
// Multi-cycle left rotator (IDLE/SHIFT/DONE) with a start/ready/done_tick handshake.
// Define ROT_LEFT_LOGSTEP_EN for fixed AMT_W-cycle log-step rotation instead of one bit per cycle.
module rotate_left_seq #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic          clk,
  input  logic          reset,
  rotate_left_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_done;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_data;
  logic [AMT_W-1:0]  r_count;

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] d,
                                             input logic [AMT_W-1:0]  n);
    logic [2*DATA_W-1:0] dd;
    dd = {d, d} << n;
    return dd[2*DATA_W-1:DATA_W];
  endfunction

`ifdef ROT_LEFT_LOGSTEP_EN
  logic [AMT_W-1:0]  r_stage;
  logic [DATA_W-1:0] w_step;

  // Stage i contributes a rotation of 2**i when bit i of the captured amount is set.
  assign w_step = r_count[r_stage] ? rotl(r_data, AMT_W'(1) << r_stage) : r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_stage <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_data  <= bus.a;
            r_count <= bus.amt;
            r_stage <= '0;
            r_ready <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_data  <= w_step;
          r_stage <= r_stage + 1'b1;
          if (r_stage == AMT_W'(AMT_W-1)) begin
            r_y     <= w_step;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
`else
  logic [DATA_W-1:0] w_rot1;

  assign w_rot1 = rotl(r_data, AMT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_data  <= bus.a;
            r_count <= bus.amt;
            r_ready <= 1'b0;
            // A zero amount skips SHIFT entirely; the operand is already the result.
            if (bus.amt == '0) begin
              r_y     <= bus.a;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_data  <= w_rot1;
          r_count <= r_count - 1'b1;
          if (r_count == AMT_W'(1)) begin
            r_y     <= w_rot1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
`endif

  assign bus.ready     = r_ready;
  assign bus.done_tick = r_done;
  assign bus.y         = r_y;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Self-checking bench for rotate_left_seq: directed table, corner sequences, random and exhaustive sweeps.
module tb_rotate_left_seq;
  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;
`ifdef ROT_LEFT_LOGSTEP_EN
  localparam bit LOGSTEP = 1'b1;
`else
  localparam bit LOGSTEP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rotate_left_if #(.DATA_W(DATA_W), .AMT_W(AMT_W)) bus ();

  rotate_left_seq #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic [7:0] exp_y;
    int         exp_lat_linear;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_rotl(input int a, input int n);
    return ((a << n) | (a >> (DATA_W - n))) & 255;
  endfunction

  function automatic int model_rotr(input int a, input int n);
    return ((a >> n) | (a << (DATA_W - n))) & 255;
  endfunction

  function automatic int exp_latency(input int amt);
    return LOGSTEP ? AMT_W + 1 : amt + 1;
  endfunction

  // Issue one operation and watch it complete; lat=0 means no done_tick inside the budget.
  task automatic run_op(input logic [7:0] a, input logic [2:0] amt,
                        output logic [7:0] y, output int lat,
                        output bit overlap, output bit busy_ready);
    int waited = 0;
    lat = 0; overlap = 0; busy_ready = 0; y = '0;
    @(negedge clk);
    while (!bus.ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    bus.start = 1'b1; bus.a = a; bus.amt = amt;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        bus.a = $urandom; bus.amt = $urandom;
      end
      if (bus.ready && bus.done_tick) overlap = 1;
      if (bus.done_tick) begin
        lat = k;
        y = bus.y;
        break;
      end
      if (bus.ready) busy_ready = 1;
    end
  endtask

  vec_t       vecs[8];
  logic [7:0] y;
  int         lat, ndone, done_k;
  bit         ov, br;

  initial begin
    vecs[0] = '{8'h93, 3'd1, 8'h27, 2};
    vecs[1] = '{8'h93, 3'd3, 8'h9C, 4};
    vecs[2] = '{8'h93, 3'd5, 8'h72, 6};
    vecs[3] = '{8'hA5, 3'd0, 8'hA5, 1};
    vecs[4] = '{8'h01, 3'd7, 8'h80, 8};
    vecs[5] = '{8'hFF, 3'd4, 8'hFF, 5};
    vecs[6] = '{8'h80, 3'd1, 8'h01, 2};
    vecs[7] = '{8'h3C, 3'd2, 8'hF0, 3};

    bus.start = 1'b0; bus.a = '0; bus.amt = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.ready, 1);
    chk("reset_done", bus.done_tick, 0);
    chk("reset_y", bus.y, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].amt, y, lat, ov, br);
      chk($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
      chk($sformatf("vec%0d_lat", i), lat, LOGSTEP ? AMT_W + 1 : vecs[i].exp_lat_linear);
      chk($sformatf("vec%0d_overlap", i), ov, 0);
      chk($sformatf("vec%0d_busy_ready", i), br, 0);
    end

    // Second start while busy must be ignored; exactly one completion.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.amt = 3'd7;
    ndone = 0; done_k = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 3) begin bus.start = 1'b1; bus.a = 8'hFF; bus.amt = 3'd1; end
      if (k == 4) bus.start = 1'b0;
      if (bus.done_tick) begin
        ndone++;
        done_k = k;
        chk("ignore_y", bus.y, 8'h80);
      end
    end
    chk("ignore_ndone", ndone, 1);
    chk("ignore_lat", done_k, exp_latency(7));
    chk("ignore_y_hold", bus.y, 8'h80);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h81; bus.amt = 3'd6;
    ndone = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done_tick) ndone++;
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_ready", bus.ready, 1);
    chk("abort_y", bus.y, 0);
    chk("abort_done", bus.done_tick, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done_tick) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(8'h81, 3'd2, y, lat, ov, br);
    chk("after_abort_y", y, 8'h06);
    chk("after_abort_lat", lat, exp_latency(2));

    // Random operations against the arithmetic model.
    for (int i = 0; i < 100; i++) begin
      logic [7:0] ra;
      logic [2:0] rn;
      ra = 8'($urandom);
      rn = 3'($urandom_range(0, 7));
      run_op(ra, rn, y, lat, ov, br);
      chk($sformatf("rand%0d_y a=%0h n=%0d", i, ra, rn), y, model_rotl(ra, rn));
      chk($sformatf("rand%0d_lat", i), lat, exp_latency(rn));
    end

    // Exhaustive round trip through a right rotation.
    for (int av = 0; av < 256; av++) begin
      for (int n = 0; n < 8; n++) begin
        run_op(8'(av), 3'(n), y, lat, ov, br);
        if (model_rotr(y, n) != av || lat != exp_latency(n) || ov || br)
          chk($sformatf("sweep a=%0h n=%0d y=%0h lat=%0d", av, n, y, lat), 0, 1);
        else
          checks++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
